// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU multicycle units.
//   - shift_type_e : shift-type codes presented on the shift_type port
//   - state_e      : shift sequencer FSM encoding
//   - DEF_*        : default datapath / shift-amount / stage-counter widths
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;
  // The stage counter must be able to hold SHAMT_W itself so that it never
  // wraps after the final SHIFT cycle.
  localparam int DEF_STAGE_W = $clog2(DEF_SHAMT_W + 1);

  typedef enum logic [1:0] {
    SHIFT_SLL     = 2'b00,
    SHIFT_SRA     = 2'b01,
    SHIFT_SRL     = 2'b10,
    SHIFT_ILLEGAL = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage : alu_pkg

// File: rtl/shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
// Combinational single-stage shifter: shifts acc by 2^stage in one direction,
// or passes acc through unchanged when enable=0 (or stage is out of range).
// Ports:
//   acc        in  WIDTH    value to shift
//   stage      in  STAGE_W  stage index; distance is 2^stage
//   shift_left in  1        1 = left (zero fill), 0 = right
//   arith      in  1        right shifts fill with acc[WIDTH-1] when set
//   enable     in  1        0 = pass acc through
//   result     out WIDTH    shifted value
// ---------------------------------------------------------------------------
module shift_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int STAGE_W = DEF_STAGE_W
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [STAGE_W-1:0] stage,
  input  logic               shift_left,
  input  logic               arith,
  input  logic               enable,
  output logic [WIDTH-1:0]   result
);

  // Fill bit for right shifts. For SRA the accumulator MSB is always the
  // original operand sign, since each stage re-fills with that same bit.
  logic fill;
  assign fill = arith & acc[WIDTH-1];

  logic [WIDTH-1:0] shl [SHAMT_W];
  logic [WIDTH-1:0] shr [SHAMT_W];

  // One fixed-distance left and right stage per power of two.
  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_dist
      localparam int DIST = 1 << gi;
      assign shl[gi] = {acc[WIDTH-1-DIST:0], {DIST{1'b0}}};
      assign shr[gi] = {{DIST{fill}}, acc[WIDTH-1:DIST]};
    end
  endgenerate

  // Stage-select mux.
  always_comb begin
    result = acc;
    if (enable) begin
      for (int i = 0; i < SHAMT_W; i++) begin
        if (stage == STAGE_W'(i)) begin
          result = shift_left ? shl[i] : shr[i];
        end
      end
    end
  end

endmodule : shift_stage

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
// Multicycle barrel-shift controller. One request is resolved one shamt bit
// per cycle (LSB first), applying at most one power-of-two stage per cycle to
// an internal accumulator, and completion is reported with a one-cycle
// data_resultRDY pulse (plus data_exception for the illegal type).
// Ports:
//   clock           in  1        rising-edge clock
//   reset           in  1        asynchronous active-high reset
//   ctrl_shift      in  1        start request, sampled only in IDLE
//   shift_type      in  2        00=SLL 01=SRA 10=SRL 11=illegal
//   data_operand    in  WIDTH    value to shift, sampled with ctrl_shift
//   ctrl_shamt      in  SHAMT_W  shift amount, sampled with ctrl_shift
//   data_result     out WIDTH    result, held until the next completion
//   data_resultRDY  out 1        one-cycle completion pulse
//   data_exception  out 1        high with data_resultRDY for illegal type
//   busy            out 1        high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module shift_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_shift,
  input  logic [1:0]         shift_type,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] ctrl_shamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               data_exception,
  output logic               busy
);

  localparam int STAGE_W = $clog2(SHAMT_W + 1);

  state_e             state_reg,  state_next;
  logic [WIDTH-1:0]   acc_reg,    acc_next;
  logic [SHAMT_W-1:0] rem_reg,    rem_next;
  logic [STAGE_W-1:0] stage_reg,  stage_next;
  shift_type_e        type_reg,   type_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               rdy_reg,    rdy_next;
  logic               exc_reg,    exc_next;

  logic [WIDTH-1:0]   stage_out;
  logic               stage_left;
  logic               stage_arith;

  assign stage_left  = (type_reg == SHIFT_SLL);
  assign stage_arith = (type_reg == SHIFT_SRA);

  shift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .STAGE_W (STAGE_W)
  ) u_stage (
    .acc        (acc_reg),
    .stage      (stage_reg),
    .shift_left (stage_left),
    .arith      (stage_arith),
    .enable     (rem_reg[0]),
    .result     (stage_out)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      rem_reg    <= '0;
      stage_reg  <= '0;
      type_reg   <= SHIFT_SLL;
      result_reg <= '0;
      rdy_reg    <= 1'b0;
      exc_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      rem_reg    <= rem_next;
      stage_reg  <= stage_next;
      type_reg   <= type_next;
      result_reg <= result_next;
      rdy_reg    <= rdy_next;
      exc_reg    <= exc_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    rem_next    = rem_reg;
    stage_next  = stage_reg;
    type_next   = type_reg;
    result_next = result_reg;

    case (state_reg)
      IDLE: begin
        if (ctrl_shift) begin
          acc_next   = data_operand;
          rem_next   = ctrl_shamt;
          type_next  = shift_type_e'(shift_type);
          stage_next = '0;
          // Illegal type skips straight to completion with the operand.
          state_next = (shift_type_e'(shift_type) == SHIFT_ILLEGAL) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        acc_next   = stage_out;
        rem_next   = rem_reg >> 1;
        stage_next = stage_reg + STAGE_W'(1);
        // Stop as soon as no set bits remain; a zero shamt still spends one
        // SHIFT cycle, which fixes the minimum latency at two.
        if (rem_next == '0) begin
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered so they appear during the DONE cycle itself;
    // capture the final accumulator on the edge that enters DONE.
    if (state_next == DONE && state_reg != DONE) begin
      result_next = acc_next;
    end
    rdy_next = (state_next == DONE);
    exc_next = (state_next == DONE) && (type_next == SHIFT_ILLEGAL);
  end

  assign data_result    = result_reg;
  assign data_resultRDY = rdy_reg;
  assign data_exception = exc_reg;
  assign busy           = (state_reg != IDLE);

endmodule : shift_sequencer

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multicycle controller for the ALU barrel-shift datapath. It accepts one shift request and resolves the 5-bit shift amount one bit per cycle, LSB first. In each cycle it applies at most one power-of-two stage (1, 2, 4, 8 or 16) to an internal accumulator. This lets the processor reuse one stage shifter instead of a full five-stage combinational shifter, and it reports completion with the same ready/exception handshake used by the mult/div units.

Parameters:
WIDTH, 32, datapath width in bits
SHAMT_W, 5, shift-amount width; must equal log2(WIDTH)

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
ctrl_shift  input  1  start request; sampled only in IDLE
shift_type  input  2  00=SLL, 01=SRA, 10=SRL, 11=illegal
data_operand  input  WIDTH  value to shift; sampled with ctrl_shift
ctrl_shamt  input  SHAMT_W  shift amount; sampled with ctrl_shift
data_result  output  WIDTH  shifted value; valid while data_resultRDY=1, held otherwise
data_resultRDY  output  1  one-cycle completion pulse
data_exception  output  1  high with data_resultRDY when shift_type=11
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; accumulator, remaining-shamt and stage counter cleared.
  - data_result=0, data_resultRDY=0, data_exception=0, busy=0.
  - An interrupted operation produces no RDY pulse.
- IDLE:
  - ctrl_shift=1 at a rising edge latches data_operand into acc, ctrl_shamt into rem, shift_type, and sets stage=0.
  - Next state: SHIFT, or DONE if shift_type=11.
  - ctrl_shift=0: remain in IDLE.
- SHIFT, one bit per cycle:
  - If rem[0]=1, acc is shifted by 2^stage.
  - Fill rules: SLL zero-fills the LSBs; SRL zero-fills the MSBs; SRA fills the MSBs with acc[WIDTH-1], which is always the original operand sign.
  - Every cycle: rem<=rem>>1, stage<=stage+1.
  - Go to DONE when the updated rem==0; otherwise stay in SHIFT.
  - At most SHAMT_W SHIFT cycles; stage never wraps.
- DONE:
  - data_result<=acc (registered), data_resultRDY=1 for exactly this one cycle, then IDLE.
  - Illegal type: data_result=original operand, data_exception=1 alongside RDY.
- Latency:
  - Let the sampling cycle be cycle 0 and p = (index of highest set bit of shamt)+1, with p=0 for shamt=0.
  - RDY is high in cycle L = 1+max(1,p). Range: L=2 to 6.
  - Illegal type: L=1.
- Handshake rules:
  - ctrl_shift while busy=1 (SHIFT or DONE) is ignored; no queueing.
  - A request may be issued in the first IDLE cycle after DONE, so back-to-back throughput is 1 op per L+1 cycles.
  - Operand, shamt and type inputs may change freely after sampling.
- Output holding:
  - data_result holds its last value until the next DONE.
  - data_exception is cleared in all cycles except DONE.

Decomposition:
- Shared package (alu_pkg):
  - Shift-type codes: SHIFT_SLL, SHIFT_SRA, SHIFT_SRL, SHIFT_ILLEGAL.
  - FSM state encoding: IDLE, SHIFT, DONE.
  - WIDTH and SHAMT_W defaults.
- One sub-module, shift_stage: a combinational single-stage shifter.
  - Inputs: acc, stage index, direction, arithmetic flag, enable.
  - Outputs: acc shifted by 2^stage, or acc unchanged when enable=0.
  - It wraps the existing per-distance left/right shift stages through a stage-select mux.
- The FSM, counters and output registers live in shift_sequencer.

Test Plan:
1. SLL, operand 0x00000001, shamt 4 -> RDY only in cycle 4, data_result=0x00000010, exception=0; busy high in cycles 1-4.
2. SRA, operand 0x80000000, shamt 31 -> RDY in cycle 6, data_result=0xFFFFFFFF. The same case with SRL -> 0x00000001, also at cycle 6.
3. SLL, operand 0xDEADBEEF, shamt 0 -> RDY in cycle 2, data_result=0xDEADBEEF. Then SRA, operand 0xF0000000, shamt 1 -> cycle 2, 0xF8000000.
4. shift_type=11, operand 0x12345678 -> RDY and data_exception both high in cycle 1, data_result=0x12345678; exception low in cycle 2.
5. SLL, operand 1, shamt 16, with a second ctrl_shift pulse (operand 0xFFFFFFFF) at cycle 2 -> a single RDY in cycle 6 with data_result=0x00010000, and no second RDY.
6. SRL, operand 0xFFFFFFFF, shamt 31, with reset pulsed during cycle 3 -> all outputs immediately 0 and no RDY. A new SLL request (operand 3, shamt 2) then completes normally: 0x0000000C at cycle 3.
